vec_issue_ctrl: RTL and testbench

Instruction issue and sequencing controller for the vector/scalar datapath. Accepts one 16-bit instruction at a time from fetch and reads the base scalar register. Single-cycle ops (VADD, SLL, SLH) are issued as a one-cycle execute pulse. VLD/VST are expanded into a 16-beat element loop against data memory, with the register-file element index and address stepped each beat. Sits between fetch and the register files / data memory; it owns busy/stall toward fetch.

---
 rtl/vec_issue_ctrl.sv | 119 +++++++++++
 tb/tb_vec_issue_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vec_issue_ctrl.sv
// vec_issue_ctrl: instruction issue/sequencing controller for the vector/scalar datapath.
//   clk, rst          : clock, synchronous active-high reset
//   instr/instr_valid : instruction from fetch; instr_ready high only when idle
//   rf_raddr/rf_rdata : scalar RF read of the base register ir[8:6]
//   op_go, op_code, dst_addr, src1_addr, src2_addr, imm, v_we, s_we : execute controls
//   elem_idx, mem_req, mem_we, mem_addr, mem_gnt : 16-beat vector memory loop
//   busy, done        : busy when not idle; done pulses on each instruction's final cycle
module vec_issue_ctrl #(
    parameter int ADDR_W = 16,
    parameter int ELEMS  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               instr,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    output logic [2:0]                rf_raddr,
    input  logic [ADDR_W-1:0]         rf_rdata,
    output logic                      op_go,
    output logic [3:0]                op_code,
    output logic [2:0]                dst_addr,
    output logic [2:0]                src1_addr,
    output logic [2:0]                src2_addr,
    output logic [7:0]                imm,
    output logic                      v_we,
    output logic                      s_we,
    output logic [$clog2(ELEMS)-1:0]  elem_idx,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_gnt,
    output logic                      busy,
    output logic                      done
);
    localparam int EW = $clog2(ELEMS);
    localparam logic [3:0] OP_VADD = 4'h0;
    localparam logic [3:0] OP_VLD  = 4'h4;
    localparam logic [3:0] OP_VST  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SLH  = 4'h7;

    typedef enum logic [1:0] {IDLE, ISSUE, MEM} state_t;

    state_t            state, state_n;
    logic [15:0]       ir, ir_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [EW-1:0]     elem, elem_n;
    logic [3:0]        op;
    logic              is_vadd, is_shift, is_mem, last;

    assign op       = ir[15:12];
    assign is_vadd  = op == OP_VADD;
    assign is_shift = op == OP_SLL || op == OP_SLH;
    assign is_mem   = op == OP_VLD || op == OP_VST;
    assign last     = elem == EW'(ELEMS - 1);

    always_comb begin
        state_n = state;
        ir_n    = ir;
        addr_n  = addr;
        elem_n  = elem;
        op_go   = 1'b0;
        v_we    = 1'b0;
        s_we    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (instr_valid) begin
                ir_n    = instr;
                state_n = ISSUE;
            end
            ISSUE: begin
                state_n = is_mem ? MEM : IDLE;
                op_go   = is_vadd || is_shift;
                v_we    = is_vadd;
                s_we    = is_shift;
                done    = !is_mem;
                if (is_mem) begin
                    addr_n = rf_rdata + ADDR_W'(ir[5:0]);
                    elem_n = '0;
                end
            end
            MEM: if (mem_gnt) begin
                v_we    = op == OP_VLD;
                addr_n  = addr + ADDR_W'(1);
                elem_n  = elem + EW'(1);
                done    = last;
                state_n = last ? IDLE : MEM;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ir    <= 16'hF000;
            addr  <= '0;
            elem  <= '0;
        end else begin
            state <= state_n;
            ir    <= ir_n;
            addr  <= addr_n;
            elem  <= elem_n;
        end
    end

    assign instr_ready = state == IDLE;
    assign busy        = !instr_ready;
    assign mem_req     = state == MEM;
    assign mem_we      = mem_req && op == OP_VST;
    assign mem_addr    = mem_req ? addr : '0;
    assign elem_idx    = mem_req ? elem : '0;
    assign rf_raddr    = ir[8:6];
    assign op_code     = op;
    assign dst_addr    = ir[11:9];
    assign src1_addr   = is_vadd ? ir[8:6] : is_shift ? ir[11:9] : 3'd0;
    assign src2_addr   = is_vadd ? ir[5:3] : 3'd0;
    assign imm         = is_shift ? ir[7:0] : 8'd0;
endmodule

// File: tb/tb_vec_issue_ctrl.sv
// tb_vec_issue_ctrl: directed bench with a transaction-level model checked every cycle.
module tb_vec_issue_ctrl;
    logic        clk = 0, rst = 1;
    logic [15:0] instr = 16'h0A58;
    logic        instr_valid = 1;
    logic        instr_ready;
    logic [2:0]  rf_raddr;
    logic [15:0] rf_rdata = 16'h0000;
    logic        op_go;
    logic [3:0]  op_code;
    logic [2:0]  dst_addr, src1_addr, src2_addr;
    logic [7:0]  imm;
    logic        v_we, s_we;
    logic [3:0]  elem_idx;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic        mem_gnt = 0;
    logic        busy, done;

    int n_cmp = 0, n_fail = 0;
    bit cmp_en = 0;

    vec_issue_ctrl #(.ADDR_W(16), .ELEMS(16)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .op_go(op_go), .op_code(op_code), .dst_addr(dst_addr), .src1_addr(src1_addr),
        .src2_addr(src2_addr), .imm(imm), .v_we(v_we), .s_we(s_we), .elem_idx(elem_idx),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction model: an accepted instruction spends one issue cycle, then
    // memory ops run until 16 granted beats have been counted.
    logic [15:0] m_ir = 16'hF000;
    logic [15:0] m_base = 0;
    bit          m_issue = 0;
    int          m_left = 0;
    int          m_k = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [3:0]  op;
            logic [15:0] ea;
            bit inmem, idle, single, shift, memop;
            op     = m_ir[15:12];
            inmem  = m_left > 0;
            idle   = !m_issue && !inmem;
            shift  = op == 4'd6 || op == 4'd7;
            single = op == 4'd0 || shift;
            memop  = op == 4'd4 || op == 4'd5;
            ea     = 16'(m_base + m_k);
            check("instr_ready", instr_ready, idle);
            check("busy", busy, !idle);
            check("op_go", op_go, m_issue && single);
            check("v_we", v_we, (m_issue && op == 0) || (inmem && mem_gnt && op == 4));
            check("s_we", s_we, m_issue && shift);
            check("done", done, (m_issue && !memop) || (inmem && mem_gnt && m_left == 1));
            check("mem_req", mem_req, inmem);
            check("mem_we", mem_we, inmem && op == 5);
            check("mem_addr", mem_addr, inmem ? ea : 16'h0);
            check("elem_idx", elem_idx, inmem ? 16'(m_k) : 16'h0);
            check("rf_raddr", rf_raddr, m_ir[8:6]);
            check("op_code", op_code, op);
            check("dst_addr", dst_addr, m_ir[11:9]);
            check("src1_addr", src1_addr, op == 0 ? m_ir[8:6] : shift ? m_ir[11:9] : 3'd0);
            check("src2_addr", src2_addr, op == 0 ? m_ir[5:3] : 3'd0);
            check("imm", imm, shift ? m_ir[7:0] : 8'd0);
            if (rst) begin
                m_ir = 16'hF000; m_issue = 0; m_left = 0; m_k = 0;
            end else if (idle && instr_valid) begin
                m_ir = instr; m_issue = 1;
            end else if (m_issue) begin
                m_issue = 0;
                if (memop) begin
                    m_base = 16'(rf_rdata + {10'd0, m_ir[5:0]});
                    m_k = 0;
                    m_left = 16;
                end
            end else if (inmem && mem_gnt) begin
                m_k++;
                m_left--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        cmp_en = 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, beat, st;
        repeat (2) tick();
        @(negedge clk);
        check("rst ready", instr_ready, 1);
        check("rst busy", busy, 0);
        check("rst mem_req", mem_req, 0);
        check("rst enables", {op_go, v_we, s_we, done, mem_we}, 0);
        rst = 0;
        tick();
        instr_valid = 0;
        @(negedge clk);
        check("vadd op_go", op_go, 1);
        check("vadd v_we", v_we, 1);
        check("vadd dst", dst_addr, 5);
        check("vadd src1", src1_addr, 1);
        check("vadd src2", src2_addr, 3);
        check("vadd done", done, 1);
        tick();
        @(negedge clk);
        check("vadd ready back", instr_ready, 1);
        instr = 16'h64AB; instr_valid = 1;
        tick();
        instr_valid = 0;
        @(negedge clk);
        check("sll s_we", s_we, 1);
        check("sll src1", src1_addr, 2);
        check("sll dst", dst_addr, 2);
        check("sll imm", imm, 16'h00AB);
        tick();
        instr = 16'hF000; instr_valid = 1;
        tick();
        instr_valid = 0;
        @(negedge clk);
        check("nop done", done, 1);
        check("nop enables", {op_go, v_we, s_we}, 0);
        tick();
        instr = 16'h4285; instr_valid = 1; rf_rdata = 16'h0100; mem_gnt = 1;
        tick();
        instr_valid = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            @(negedge clk);
            check("vld addr", mem_addr, 16'h0105 + 16'(k));
            check("vld elem", elem_idx, 16'(k));
            check("vld v_we", v_we, 1);
            check("vld done", done, k == 15);
        end
        tick();
        @(negedge clk);
        check("vld ready back", instr_ready, 1);
        instr = 16'h5000; instr_valid = 1; rf_rdata = 16'hFFFE;
        tick();
        instr_valid = 0;
        cyc = 0; beat = 0; st = 0;
        do begin
            tick();
            cyc++;
            if ((beat == 0 || beat == 7) && st < 2) begin
                mem_gnt = 0; st++;
            end else begin
                mem_gnt = 1; st = 0;
            end
            @(negedge clk);
            check("vst addr", mem_addr, 16'(16'hFFFE + beat));
            check("vst mem_we", mem_we, 1);
            check("vst v_we", v_we, 0);
            if (mem_gnt) beat++;
        end while (!done && cyc < 40);
        check("vst total cycles", 16'(cyc + 2), 22);
        check("vst beats", 16'(beat), 16);
        tick();
        mem_gnt = 1;
        instr = 16'h4285; instr_valid = 1; rf_rdata = 16'h0100;
        tick();
        instr_valid = 0;
        cyc = 0;
        do begin
            tick();
            cyc++;
            @(negedge clk);
        end while (elem_idx != 6 && cyc < 40);
        check("pre-reset elem", elem_idx, 6);
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        check("abort mem_req", mem_req, 0);
        check("abort done", done, 0);
        check("abort ready", instr_ready, 1);
        instr_valid = 1;
        tick();
        instr_valid = 0;
        tick();
        @(negedge clk);
        check("restart elem", elem_idx, 0);
        check("restart addr", mem_addr, 16'h0105);
        repeat (20) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
